// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC alarm timer: register byte addresses and
// CTRL register bit positions.
package rtc_pkg;

  localparam int unsigned ADDR_CTRL       = 32'h00;
  localparam int unsigned ADDR_TIME       = 32'h04;
  localparam int unsigned ADDR_CLR        = 32'h08;
  localparam int unsigned ADDR_STATUS     = 32'h0C;
  localparam int unsigned ADDR_ALARM_BASE = 32'h10;

  localparam int unsigned CTRL_RUN_BIT    = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

endpackage

// File: rtl/rtc_alarm_timer_prescaler.sv
// Tick-enable prescaler: counts 0..DIV_CNT-1 while en is high and flags the
// wrap cycle. sync_clr restarts the count and swallows a coincident wrap.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - count enable (holds count when low)
//   sync_clr  - synchronous restart to 0
//   tick      - combinational wrap indicator for this cycle
module rtc_prescaler #(
  parameter int unsigned DIV_CNT   = 50000000,
  parameter int unsigned CNT_WIDTH = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DIV_CNT - 1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 wrap;

  always_comb begin
    wrap = en && (cnt_q == LAST);
    tick = wrap && !sync_clr;
    cnt_d = cnt_q;
    if (sync_clr || wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_alarm_timer.sv
// CPU-mapped real-time counter with run/stop, time load, clear, N alarm
// match channels with sticky W1C status, and a level interrupt.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   wr/waddr/wdata  - register write strobe, byte address, data
//   rd/raddr/rdata  - register read strobe, byte address, registered data
//   run_time        - current time count
//   tick            - one-cycle pulse on each run_time advance
//   irq             - registered interrupt level (irq_en & |status)
module rtc_alarm_timer
  import rtc_pkg::*;
#(
  parameter int unsigned ADDRWIDTH   = 6,
  parameter int unsigned DIV_CNT     = 50000000,
  parameter int unsigned CNT_WIDTH   = 26,
  parameter int unsigned RELOAD_TIME = 86400,
  parameter int unsigned TIME_WIDTH  = 17,
  parameter int unsigned N_ALARM     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [ADDRWIDTH-1:0]  waddr,
  input  logic [31:0]           wdata,
  input  logic                  rd,
  input  logic [ADDRWIDTH-1:0]  raddr,
  output logic [31:0]           rdata,
  output logic [TIME_WIDTH-1:0] run_time,
  output logic                  tick,
  output logic                  irq
);

  // One extra bit so RELOAD_TIME == 2**TIME_WIDTH still compares correctly.
  localparam logic [TIME_WIDTH:0]   RELOAD_EXT = (TIME_WIDTH + 1)'(RELOAD_TIME);
  localparam logic [TIME_WIDTH-1:0] TIME_LAST  = TIME_WIDTH'(RELOAD_TIME - 1);

  function automatic logic addr_is(input logic [ADDRWIDTH-1:0] a, input int unsigned target);
    return 32'(a) == target;
  endfunction

  logic                                run_q, run_d;
  logic                                irq_en_q, irq_en_d;
  logic [TIME_WIDTH-1:0]               time_q, time_d;
  logic [N_ALARM-1:0]                  status_q, status_d;
  logic [N_ALARM-1:0][TIME_WIDTH-1:0]  alarm_val_q, alarm_val_d;
  logic [N_ALARM-1:0]                  alarm_en_q, alarm_en_d;
  logic [31:0]                         rdata_q, rdata_d;
  logic                                irq_q, irq_d;
  logic                                tick_q, tick_d;

  logic                  clr_wr, load_wr, presc_tick;
  logic [TIME_WIDTH-1:0] load_val;
  logic [N_ALARM-1:0]    set_vec, w1c_mask;
  logic                  unused_wdata;

  assign unused_wdata = ^wdata;

  always_comb begin
    clr_wr  = wr && addr_is(waddr, ADDR_CLR);
    load_wr = wr && addr_is(waddr, ADDR_TIME);
  end

  // A prescaler wrap coinciding with CLR/LOAD is dropped inside the prescaler,
  // so presc_tick alone decides whether run_time advances.
  rtc_prescaler #(
    .DIV_CNT   (DIV_CNT),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (run_q),
    .sync_clr (clr_wr || load_wr),
    .tick     (presc_tick)
  );

  always_comb begin
    run_d       = run_q;
    irq_en_d    = irq_en_q;
    alarm_val_d = alarm_val_q;
    alarm_en_d  = alarm_en_q;
    if (wr && addr_is(waddr, ADDR_CTRL)) begin
      run_d    = wdata[CTRL_RUN_BIT];
      irq_en_d = wdata[CTRL_IRQ_EN_BIT];
    end
    for (int unsigned i = 0; i < N_ALARM; i++) begin
      if (wr && addr_is(waddr, ADDR_ALARM_BASE + 4 * i)) begin
        alarm_val_d[i] = wdata[TIME_WIDTH-1:0];
        alarm_en_d[i]  = wdata[31];
      end
    end

    load_val = wdata[TIME_WIDTH-1:0];
    if ({1'b0, load_val} >= RELOAD_EXT) begin
      load_val = '0;
    end

    time_d = time_q;
    if (clr_wr) begin
      time_d = '0;
    end else if (load_wr) begin
      time_d = load_val;
    end else if (presc_tick) begin
      time_d = (time_q == TIME_LAST) ? '0 : time_q + 1'b1;
    end
    tick_d = presc_tick;

    // Only tick-driven updates can match; an out-of-range alarm value can
    // never equal time_d, so it never fires.
    for (int unsigned i = 0; i < N_ALARM; i++) begin
      set_vec[i] = presc_tick && alarm_en_q[i] && (alarm_val_q[i] == time_d);
    end
    w1c_mask = (wr && addr_is(waddr, ADDR_STATUS)) ? wdata[N_ALARM-1:0] : '0;
    status_d = (status_q & ~w1c_mask) | set_vec;

    irq_d = irq_en_q && (|status_q);

    rdata_d = '0;
    if (rd) begin
      if (addr_is(raddr, ADDR_CTRL)) begin
        rdata_d[CTRL_RUN_BIT]    = run_q;
        rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      if (addr_is(raddr, ADDR_TIME)) begin
        rdata_d[TIME_WIDTH-1:0] = time_q;
      end
      if (addr_is(raddr, ADDR_STATUS)) begin
        rdata_d[N_ALARM-1:0] = status_q;
      end
      for (int unsigned i = 0; i < N_ALARM; i++) begin
        if (addr_is(raddr, ADDR_ALARM_BASE + 4 * i)) begin
          rdata_d[TIME_WIDTH-1:0] = alarm_val_q[i];
          rdata_d[31]             = alarm_en_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      time_q      <= '0;
      status_q    <= '0;
      alarm_val_q <= '0;
      alarm_en_q  <= '0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      run_q       <= run_d;
      irq_en_q    <= irq_en_d;
      time_q      <= time_d;
      status_q    <= status_d;
      alarm_val_q <= alarm_val_d;
      alarm_en_q  <= alarm_en_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      tick_q      <= tick_d;
    end
  end

  assign rdata    = rdata_q;
  assign run_time = time_q;
  assign tick     = tick_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_rtc_alarm_timer.sv
module tb_rtc_alarm_timer;

  localparam int AW = 6;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr, rd;
  logic [AW-1:0] waddr, raddr;
  logic [31:0]   wdata, rdata;
  logic [TW-1:0] run_time;
  logic          tick, irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rtc_alarm_timer #(
    .ADDRWIDTH   (AW),
    .DIV_CNT     (4),
    .CNT_WIDTH   (2),
    .RELOAD_TIME (10),
    .TIME_WIDTH  (TW),
    .N_ALARM     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .waddr    (waddr),
    .wdata    (wdata),
    .rd       (rd),
    .raddr    (raddr),
    .rdata    (rdata),
    .run_time (run_time),
    .tick     (tick),
    .irq      (irq)
  );

  typedef struct {
    logic        wr;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        rd;
    logic [5:0]  raddr;
    logic [3:0]  e_rt;
    logic        e_tick;
    logic [31:0] e_rdata;
    logic        e_irq;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic w, input logic [5:0] wa, input logic [31:0] wd,
                              input logic r, input logic [5:0] ra, input logic [3:0] ert,
                              input logic etk, input logic [31:0] erd, input logic eirq);
    vec_t v;
    v.wr = w; v.waddr = wa; v.wdata = wd; v.rd = r; v.raddr = ra;
    v.e_rt = ert; v.e_tick = etk; v.e_rdata = erd; v.e_irq = eirq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ert, input logic etk,
                            input logic [31:0] erd, input logic eirq);
    check({tag, "_rt"}, 32'(run_time), 32'(ert));
    check({tag, "_tick"}, 32'(tick), 32'(etk));
    check({tag, "_rdata"}, rdata, erd);
    check({tag, "_irq"}, 32'(irq), 32'(eirq));
  endtask

  // Drive one access at a negedge; returns at the next negedge, after the
  // intervening posedge has applied it.
  task automatic cycle(input logic w, input logic [5:0] wa, input logic [31:0] wd,
                       input logic r, input logic [5:0] ra);
    wr = w; waddr = wa; wdata = wd; rd = r; raddr = ra;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 6'h00, 32'h0, 1'b0, 6'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    rst = 1'b1; wr = 1'b0; rd = 1'b0; waddr = '0; raddr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check_outs("reset", 4'd0, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;

    //          wr    waddr  wdata         rd    raddr  rt    tick  rdata         irq
    vecs[0]  = mk(1'b1, 6'h00, 32'h3,        1'b0, 6'h00, 4'd0, 1'b0, 32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd0, 1'b0, 32'h0,        1'b0);
    vecs[2]  = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd0, 1'b0, 32'h0,        1'b0);
    vecs[3]  = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd0, 1'b0, 32'h0,        1'b0);
    vecs[4]  = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd1, 1'b1, 32'h0,        1'b0);
    vecs[5]  = mk(1'b0, 6'h00, 32'h0,        1'b1, 6'h04, 4'd1, 1'b0, 32'h1,        1'b0);
    vecs[6]  = mk(1'b1, 6'h10, 32'h80000003, 1'b0, 6'h00, 4'd1, 1'b0, 32'h0,        1'b0);
    vecs[7]  = mk(1'b0, 6'h00, 32'h0,        1'b1, 6'h10, 4'd1, 1'b0, 32'h80000003, 1'b0);
    vecs[8]  = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd2, 1'b1, 32'h0,        1'b0);
    vecs[9]  = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd2, 1'b0, 32'h0,        1'b0);
    vecs[10] = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd2, 1'b0, 32'h0,        1'b0);
    vecs[11] = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd2, 1'b0, 32'h0,        1'b0);
    vecs[12] = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd3, 1'b1, 32'h0,        1'b0);
    vecs[13] = mk(1'b0, 6'h00, 32'h0,        1'b1, 6'h0C, 4'd3, 1'b0, 32'h1,        1'b1);
    vecs[14] = mk(1'b1, 6'h0C, 32'h1,        1'b0, 6'h00, 4'd3, 1'b0, 32'h0,        1'b1);
    vecs[15] = mk(1'b0, 6'h00, 32'h0,        1'b1, 6'h0C, 4'd3, 1'b0, 32'h0,        1'b0);
    vecs[16] = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd4, 1'b1, 32'h0,        1'b0);
    vecs[17] = mk(1'b1, 6'h04, 32'd7,        1'b0, 6'h00, 4'd7, 1'b0, 32'h0,        1'b0);
    vecs[18] = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd7, 1'b0, 32'h0,        1'b0);
    vecs[19] = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd7, 1'b0, 32'h0,        1'b0);
    vecs[20] = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd7, 1'b0, 32'h0,        1'b0);
    vecs[21] = mk(1'b0, 6'h00, 32'h0,        1'b0, 6'h00, 4'd8, 1'b1, 32'h0,        1'b0);
    vecs[22] = mk(1'b1, 6'h04, 32'd12,       1'b0, 6'h00, 4'd0, 1'b0, 32'h0,        1'b0);
    vecs[23] = mk(1'b1, 6'h14, 32'h80000005, 1'b0, 6'h00, 4'd0, 1'b0, 32'h0,        1'b0);
    vecs[24] = mk(1'b1, 6'h04, 32'd5,        1'b0, 6'h00, 4'd5, 1'b0, 32'h0,        1'b0);
    vecs[25] = mk(1'b0, 6'h00, 32'h0,        1'b1, 6'h0C, 4'd5, 1'b0, 32'h0,        1'b0);
    vecs[26] = mk(1'b0, 6'h00, 32'h0,        1'b1, 6'h00, 4'd5, 1'b0, 32'h3,        1'b0);
    vecs[27] = mk(1'b1, 6'h3C, 32'hFFFFFFFF, 1'b1, 6'h3C, 4'd5, 1'b0, 32'h0,        1'b0);
    vecs[28] = mk(1'b1, 6'h10, 32'h0,        1'b0, 6'h00, 4'd6, 1'b1, 32'h0,        1'b0);

    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].rd, vecs[i].raddr);
      check_outs($sformatf("v%0d", i), vecs[i].e_rt, vecs[i].e_tick, vecs[i].e_rdata, vecs[i].e_irq);
    end

    // Wrap 9 -> 0 and run up to 5: only ALARM1 (enabled, value 5) may fire.
    cycle(1'b1, 6'h04, 32'd9, 1'b0, 6'h00);
    check_outs("load9", 4'd9, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      idle();
      check($sformatf("wrap%0d_rt", k), 32'(run_time), 32'((9 + k / 4) % 10));
      check($sformatf("wrap%0d_tick", k), 32'(tick), 32'((k % 4) == 0));
    end
    cycle(1'b0, 6'h00, 32'h0, 1'b1, 6'h0C);
    check_outs("alarm1", 4'd5, 1'b0, 32'h2, 1'b1);
    cycle(1'b1, 6'h0C, 32'h2, 1'b0, 6'h00);

    // CLR landing exactly on a tick: tick suppressed, prescaler restarts.
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      idle();
      if (tick === 1'b1) found = 1'b1;
    end
    check("sync_tick_found", 32'(found), 32'h1);
    for (int k = 0; k < 3; k++) begin
      idle();
      check($sformatf("pre_clr%0d_tick", k), 32'(tick), 32'h0);
    end
    cycle(1'b1, 6'h08, 32'h0, 1'b0, 6'h00);
    check_outs("clr_on_tick", 4'd0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 6'h18, 32'h80000001, 1'b0, 6'h00);
    check_outs("post_clr1", 4'd0, 1'b0, 32'h0, 1'b0);
    idle();
    check_outs("post_clr2", 4'd0, 1'b0, 32'h0, 1'b0);
    idle();
    check_outs("post_clr3", 4'd0, 1'b0, 32'h0, 1'b0);
    // W1C of bit 2 in the same cycle the tick sets it: set wins.
    cycle(1'b1, 6'h0C, 32'h4, 1'b0, 6'h00);
    check_outs("w1c_vs_set", 4'd1, 1'b1, 32'h0, 1'b0);
    cycle(1'b0, 6'h00, 32'h0, 1'b1, 6'h0C);
    check_outs("status_kept", 4'd1, 1'b0, 32'h4, 1'b1);

    // run=0 freezes run_time and prescaler; resuming completes the old count.
    cycle(1'b1, 6'h00, 32'h2, 1'b0, 6'h00);
    check_outs("stop", 4'd1, 1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      idle();
      check($sformatf("frozen%0d_rt", k), 32'(run_time), 32'h1);
      check($sformatf("frozen%0d_tick", k), 32'(tick), 32'h0);
    end
    cycle(1'b1, 6'h00, 32'h3, 1'b0, 6'h00);
    check_outs("resume0", 4'd1, 1'b0, 32'h0, 1'b1);
    idle();
    check_outs("resume1", 4'd1, 1'b0, 32'h0, 1'b1);
    idle();
    check_outs("resume2", 4'd2, 1'b1, 32'h0, 1'b1);
    cycle(1'b0, 6'h00, 32'h0, 1'b1, 6'h04);
    check_outs("pre_rst", 4'd2, 1'b0, 32'h2, 1'b1);

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 4'd0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
